// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS control sequencer: walks each instruction through fetch/decode/execute/
// memory/write-back states, stalls on the memory handshake and counts retired instructions.
module multicycle_control_fsm #(
    parameter int unsigned COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [5:0]             instr_op,
    input  logic                   mem_ready,
    output logic                   pc_write,
    output logic                   pc_write_cond,
    output logic                   i_or_d,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic                   ir_write,
    output logic                   mem_to_reg,
    output logic                   reg_dst,
    output logic                   reg_write,
    output logic                   alu_src_a,
    output logic [1:0]             alu_src_b,
    output logic [1:0]             alu_op,
    output logic [1:0]             pc_source,
    output logic [3:0]             state,
    output logic                   instr_done,
    output logic                   illegal_op,
    output logic [COUNT_WIDTH-1:0] instr_count
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAddr  = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecute  = 4'd6,
        StRWb      = 4'd7,
        StBranch   = 4'd8,
        StJump     = 4'd9,
        StAddiExec = 4'd10,
        StAddiWb   = 4'd11
    } state_e;

    state_e state_q, state_d;
    logic [COUNT_WIDTH-1:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StFetch;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if (instr_done) count_q <= count_q + 1'b1;
        end
    end

    always_comb begin
        state_d       = StFetch;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        instr_done    = 1'b0;
        illegal_op    = 1'b0;

        case (state_q)
            StFetch: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                state_d   = mem_ready ? StDecode : StFetch;
            end
            StDecode: begin
                alu_src_b = 2'b11;
                case (instr_op)
                    OP_LW, OP_SW: state_d = StMemAddr;
                    OP_RTYPE:     state_d = StExecute;
                    OP_BEQ:       state_d = StBranch;
                    OP_J:         state_d = StJump;
                    OP_ADDI:      state_d = StAddiExec;
                    default: begin
                        state_d    = StFetch;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            StMemAddr: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (instr_op == OP_SW) ? StMemWrite : StMemRead;
            end
            StMemRead: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                state_d  = mem_ready ? StMemWb : StMemRead;
            end
            StMemWb: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            StMemWrite: begin
                mem_write  = 1'b1;
                i_or_d     = 1'b1;
                instr_done = mem_ready;
                state_d    = mem_ready ? StFetch : StMemWrite;
            end
            StExecute: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_d   = StRWb;
            end
            StRWb: begin
                reg_dst    = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            StBranch: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                instr_done    = 1'b1;
            end
            StJump: begin
                pc_write   = 1'b1;
                pc_source  = 2'b10;
                instr_done = 1'b1;
            end
            StAddiExec: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = StAddiWb;
            end
            StAddiWb: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            default: state_d = StFetch;
        endcase

        // Reset leaves state at FETCH, so only the strobes need masking here.
        if (rst) begin
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            ir_write      = 1'b0;
            reg_write     = 1'b0;
            instr_done    = 1'b0;
            illegal_op    = 1'b0;
        end
    end

    assign state       = state_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: walks each instruction class with hand-computed
// state sequences and control values, plus illegal opcode, counter wrap and mid-access reset.
module tb_multicycle_control_fsm;

    logic       clk, rst;
    logic [5:0] instr_op;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state;
    logic       instr_done, illegal_op;
    logic [3:0] instr_count;

    int n_cmp = 0;
    int n_err = 0;

    multicycle_control_fsm #(.COUNT_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .instr_op(instr_op), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .state(state), .instr_done(instr_done),
        .illegal_op(illegal_op), .instr_count(instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Zero-wait fetch followed by the decode cycle; leaves the bench one edge past DECODE.
    task automatic fetch_decode(input logic [5:0] op);
        instr_op  = op;
        mem_ready = 1'b1;
        #1;
        chk4("fetch_state", state, 4'd0);
        chk1("fetch_ir_write", ir_write, 1'b1);
        chk1("fetch_pc_write", pc_write, 1'b1);
        tick();
        chk4("decode_state", state, 4'd1);
        chk2("decode_alu_src_b", alu_src_b, 2'b11);
        tick();
    endtask

    task automatic run_j(input logic [3:0] cnt_before);
        fetch_decode(6'b000010);
        chk4("j_state", state, 4'd9);
        chk1("j_pc_write", pc_write, 1'b1);
        chk2("j_pc_source", pc_source, 2'b10);
        chk1("j_done", instr_done, 1'b1);
        tick();
        chk4("j_count", instr_count, cnt_before + 4'd1);
    endtask

    initial begin
        rst       = 1'b1;
        instr_op  = 6'd0;
        mem_ready = 1'b1;
        tick();
        // Reset state
        chk4("rst_state", state, 4'd0);
        chk4("rst_count", instr_count, 4'd0);
        chk1("rst_mem_read", mem_read, 1'b0);
        chk1("rst_ir_write", ir_write, 1'b0);
        chk1("rst_pc_write", pc_write, 1'b0);
        chk2("rst_alu_src_b", alu_src_b, 2'b01);
        rst = 1'b0;
        #1;
        chk1("post_rst_mem_read", mem_read, 1'b1);

        // R-type, mem_ready held high: 0,1,6,7,0
        fetch_decode(6'b000000);
        chk4("r_exec_state", state, 4'd6);
        chk2("r_exec_alu_op", alu_op, 2'b10);
        chk1("r_exec_done", instr_done, 1'b0);
        tick();
        chk4("r_wb_state", state, 4'd7);
        chk1("r_wb_reg_write", reg_write, 1'b1);
        chk1("r_wb_reg_dst", reg_dst, 1'b1);
        chk1("r_wb_done", instr_done, 1'b1);
        chk4("r_wb_count_before", instr_count, 4'd0);
        tick();
        chk4("r_end_state", state, 4'd0);
        chk4("r_count", instr_count, 4'd1);

        // lw with 2 FETCH waits and 1 MEM_READ wait: 8 cycles
        instr_op  = 6'b100011;
        mem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk4("lw_fetch_wait_state", state, 4'd0);
            chk1("lw_fetch_wait_mem_read", mem_read, 1'b1);
            chk1("lw_fetch_wait_ir_write", ir_write, 1'b0);
            tick();
        end
        mem_ready = 1'b1;
        #1;
        chk1("lw_fetch_ir_write", ir_write, 1'b1);
        tick();
        chk4("lw_decode_state", state, 4'd1);
        tick();
        chk4("lw_addr_state", state, 4'd2);
        chk2("lw_addr_alu_src_b", alu_src_b, 2'b10);
        chk1("lw_addr_alu_src_a", alu_src_a, 1'b1);
        tick();
        mem_ready = 1'b0;
        #1;
        chk4("lw_read_wait_state", state, 4'd3);
        chk1("lw_read_mem_read", mem_read, 1'b1);
        chk1("lw_read_i_or_d", i_or_d, 1'b1);
        tick();
        mem_ready = 1'b1;
        #1;
        chk4("lw_read_state", state, 4'd3);
        chk1("lw_read_i_or_d2", i_or_d, 1'b1);
        tick();
        chk4("lw_wb_state", state, 4'd4);
        chk1("lw_wb_mem_to_reg", mem_to_reg, 1'b1);
        chk1("lw_wb_reg_write", reg_write, 1'b1);
        chk1("lw_wb_mem_read", mem_read, 1'b0);
        tick();
        chk4("lw_end_state", state, 4'd0);
        chk4("lw_count", instr_count, 4'd2);

        // sw with 3 MEM_WRITE waits
        fetch_decode(6'b101011);
        chk4("sw_addr_state", state, 4'd2);
        tick();
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk4("sw_write_wait_state", state, 4'd5);
            chk1("sw_write_wait_mem_write", mem_write, 1'b1);
            chk1("sw_write_wait_i_or_d", i_or_d, 1'b1);
            chk1("sw_write_wait_done", instr_done, 1'b0);
            tick();
        end
        mem_ready = 1'b1;
        #1;
        chk1("sw_write_mem_write", mem_write, 1'b1);
        chk1("sw_write_done", instr_done, 1'b1);
        chk4("sw_count_before", instr_count, 4'd2);
        tick();
        chk4("sw_end_state", state, 4'd0);
        chk4("sw_count", instr_count, 4'd3);

        // beq, j, addi
        fetch_decode(6'b000100);
        chk4("beq_state", state, 4'd8);
        chk1("beq_pc_write_cond", pc_write_cond, 1'b1);
        chk2("beq_pc_source", pc_source, 2'b01);
        chk2("beq_alu_op", alu_op, 2'b01);
        chk1("beq_pc_write", pc_write, 1'b0);
        tick();
        chk4("beq_count", instr_count, 4'd4);
        run_j(4'd4);
        fetch_decode(6'b001000);
        chk4("addi_exec_state", state, 4'd10);
        chk2("addi_exec_alu_src_b", alu_src_b, 2'b10);
        tick();
        chk4("addi_wb_state", state, 4'd11);
        chk1("addi_wb_reg_dst", reg_dst, 1'b0);
        chk1("addi_wb_reg_write", reg_write, 1'b1);
        chk1("addi_wb_mem_to_reg", mem_to_reg, 1'b0);
        tick();
        chk4("addi_count", instr_count, 4'd6);

        // Illegal opcode
        instr_op = 6'b111111;
        #1;
        tick();
        chk4("ill_decode_state", state, 4'd1);
        chk1("ill_flag", illegal_op, 1'b1);
        chk1("ill_done", instr_done, 1'b0);
        tick();
        chk4("ill_next_state", state, 4'd0);
        chk1("ill_flag_clear", illegal_op, 1'b0);
        chk4("ill_count", instr_count, 4'd6);

        // Counter wrap at 4 bits
        for (int c = 6; c < 15; c++) run_j(4'(c));
        chk4("wrap_count_15", instr_count, 4'd15);
        run_j(4'd15);
        chk4("wrap_count_0", instr_count, 4'd0);

        // Reset during stalled MEM_READ
        fetch_decode(6'b000000);
        tick();
        tick();
        chk4("pre_rst_count", instr_count, 4'd1);
        fetch_decode(6'b100011);
        tick();
        mem_ready = 1'b0;
        #1;
        chk4("stall_state", state, 4'd3);
        rst = 1'b1;
        #1;
        chk4("mid_rst_state", state, 4'd0);
        chk4("mid_rst_count", instr_count, 4'd0);
        chk1("mid_rst_mem_read", mem_read, 1'b0);
        chk1("mid_rst_i_or_d", i_or_d, 1'b0);
        chk1("mid_rst_done", instr_done, 1'b0);
        tick();
        chk1("mid_rst_hold_mem_read", mem_read, 1'b0);
        rst = 1'b0;
        #1;
        chk1("rel_mem_read", mem_read, 1'b1);
        chk1("rel_ir_write", ir_write, 1'b0);
        tick();
        chk4("rel_state_hold", state, 4'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
